// File: rtl/aes_pkg.sv
// Shared AES constants: S-box, round constants, round count and key-schedule FSM states.
// Used by both the key expansion and the encrypt datapath.
package aes_pkg;

    localparam int NUM_ROUNDS = 10;

    typedef enum logic {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Index n holds rcon for round n; unused slots are zero.
    localparam logic [0:15][7:0] RCON = {
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[x];
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single-byte AES S-box lookup, purely combinational.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] x,
    output logic [7:0] y
);

    assign y = sbox(x);

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: streams round keys 0..10 one per cycle and
// keeps all of them in a register file with a combinational read port.
module aes_key_expand #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key,
    output logic         busy,
    output logic         rk_valid,
    output logic [3:0]   rk_idx,
    output logic [127:0] round_key,
    output logic         done,
    output logic         keys_ready,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key
);

    import aes_pkg::*;

    localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

    state_t       state;
    state_t       state_nx;
    logic [127:0] slots [0:10];
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rot, sub;
    logic [31:0]  n0, n1, n2, n3;
    logic [127:0] nxt;
    logic [3:0]   idx_nx;
    logic         accept, step, finish;

    assign {w0, w1, w2, w3} = round_key;
    assign rot    = {w3[23:0], w3[31:24]};
    assign idx_nx = rk_idx + 4'd1;

    aes_sbox u_sb0 (.x(rot[31:24]), .y(sub[31:24]));
    aes_sbox u_sb1 (.x(rot[23:16]), .y(sub[23:16]));
    aes_sbox u_sb2 (.x(rot[15:8]),  .y(sub[15:8]));
    aes_sbox u_sb3 (.x(rot[7:0]),   .y(sub[7:0]));

    assign n0  = w0 ^ sub ^ {RCON[idx_nx], 24'h0};
    assign n1  = w1 ^ n0;
    assign n2  = w2 ^ n1;
    assign n3  = w3 ^ n2;
    assign nxt = {n0, n1, n2, n3};

    assign busy   = (state == EXPAND);
    assign accept = (state == IDLE) && start;
    assign step   = busy && (rk_idx != LAST);
    assign finish = busy && (rk_idx == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (accept) state_nx = EXPAND;
        if (finish) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            round_key  <= '0;
            rk_idx     <= '0;
            rk_valid   <= 1'b0;
            done       <= 1'b0;
            keys_ready <= 1'b0;
            for (int i = 0; i < 11; i++) slots[i] <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                round_key  <= key;
                rk_idx     <= '0;
                rk_valid   <= 1'b1;
                keys_ready <= 1'b0;
                slots[0]   <= key;
            end else if (step) begin
                round_key      <= nxt;
                rk_idx         <= idx_nx;
                rk_valid       <= 1'b1;
                slots[idx_nx]  <= nxt;
                done           <= (idx_nx == LAST);
            end else if (finish) begin
                rk_valid   <= 1'b0;
                keys_ready <= 1'b1;
            end
        end
    end

    // Addresses past the last round read as zero.
    assign rd_key = (rd_idx <= LAST) ? slots[rd_idx] : '0;

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand: FIPS-197 key schedules checked through
// a scoreboard queue, plus latency, read-port, start-filtering and reset cases.
module tb_aes_key_expand;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] key;
    logic         busy;
    logic         rk_valid;
    logic [3:0]   rk_idx;
    logic [127:0] round_key;
    logic         done;
    logic         keys_ready;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;

    int errors   = 0;
    int checks   = 0;
    int done_cnt = 0;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] key;
        logic         done;
    } exp_t;

    exp_t exp_q [$];

    logic [127:0] ka [0:10] = '{
        128'h000102030405060708090a0b0c0d0e0f,
        128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
        128'hb692cf0b643dbdf1be9bc5006830b3fe,
        128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
        128'h47f7f7bc95353e03f96c32bcfd058dfd,
        128'h3caaa3e8a99f9deb50f3af57adf622aa,
        128'h5e390f7df7a69296a7553dc10aa31f6b,
        128'h14f9701ae35fe28c440adf4d4ea9c026,
        128'h47438735a41c65b9e016baf4aebf7ad2,
        128'h549932d1f08557681093ed9cbe2c974e,
        128'h13111d7fe3944a17f307a78b4d2b30c5
    };

    logic [127:0] kb [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    aes_key_expand dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .key        (key),
        .busy       (busy),
        .rk_valid   (rk_valid),
        .rk_idx     (rk_idx),
        .round_key  (round_key),
        .done       (done),
        .keys_ready (keys_ready),
        .rd_idx     (rd_idx),
        .rd_key     (rd_key)
    );

    always #5 clk = ~clk;

    // Monitor: every valid round key must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rk_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rk idx=%0d key=%h", rk_idx, round_key);
            end else begin
                e = exp_q.pop_front();
                if (rk_idx !== e.idx || round_key !== e.key || done !== e.done) begin
                    errors++;
                    $display("FAIL stream got idx=%0d key=%h done=%b need idx=%0d key=%h done=%b",
                             rk_idx, round_key, done, e.idx, e.key, e.done);
                end
            end
        end
        if (rst_n && done && !rk_valid) begin
            checks++;
            errors++;
            $display("FAIL done_without_valid idx=%0d", rk_idx);
        end
        if (rst_n && done) done_cnt++;
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] need);
        checks++;
        if (got !== need) begin
            errors++;
            $display("FAIL %s got=%h need=%h", name, got, need);
        end
    endtask

    task automatic push_exp(input bit sel);
        for (int i = 0; i <= 10; i++)
            exp_q.push_back('{idx: 4'(i), key: (sel ? kb[i] : ka[i]), done: (i == 10)});
    endtask

    task automatic start_exp(input bit sel);
        @(negedge clk);
        key   = sel ? kb[0] : ka[0];
        start = 1'b1;
        push_exp(sel);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts cycles from the start edge until done; expects 11.
    task automatic wait_done();
        int n = 0;
        for (int i = 1; i <= 20 && n == 0; i++) begin
            @(negedge clk);
            if (done) n = i;
        end
        check("done_latency", 128'(n), 128'd11);
        @(posedge clk);
        #1;
        check("keys_ready_end", 128'(keys_ready), 128'd1);
        check("busy_end", 128'(busy), 128'd0);
        check("queue_drained", 128'(exp_q.size()), 128'd0);
    endtask

    initial begin
        int d0;
        int n;
        rst_n  = 1'b0;
        start  = 1'b0;
        key    = '0;
        rd_idx = '0;
        #1;
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_valid", 128'(rk_valid), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_ready", 128'(keys_ready), 128'd0);
        check("rst_idx", 128'(rk_idx), 128'd0);
        check("rst_rk", round_key, 128'h0);
        check("rst_slot0", rd_key, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero-based key, plus busy during the first streamed cycle
        start_exp(1'b0);
        check("busy_first", 128'(busy), 128'd1);
        d0 = done_cnt;
        wait_done();
        check("done_once_a", 128'(done_cnt - d0), 128'd1);

        // FIPS key, then read every slot back
        start_exp(1'b1);
        wait_done();
        for (int i = 0; i <= 10; i++) begin
            rd_idx = 4'(i);
            #1 check($sformatf("rd_slot%0d", i), rd_key, kb[i]);
        end
        rd_idx = 4'd11;
        #1 check("rd_slot11", rd_key, 128'h0);
        rd_idx = 4'd15;
        #1 check("rd_slot15", rd_key, 128'h0);

        // start held across the whole busy window, including the done cycle
        @(negedge clk);
        key   = ka[0];
        start = 1'b1;
        push_exp(1'b0);
        d0 = done_cnt;
        n  = 0;
        for (int i = 1; i <= 20 && n == 0; i++) begin
            @(negedge clk);
            if (done) n = i;
        end
        check("held_latency", 128'(n), 128'd11);
        @(posedge clk);
        #1 start = 1'b0;
        check("held_not_restarted", 128'(busy), 128'd0);
        repeat (4) @(negedge clk);
        check("held_done_once", 128'(done_cnt - d0), 128'd1);
        check("held_queue", 128'(exp_q.size()), 128'd0);

        // start pulsed only in the done cycle
        start_exp(1'b1);
        n = 0;
        for (int i = 1; i <= 20 && n == 0; i++) begin
            @(negedge clk);
            if (done) n = i;
        end
        check("pulse_latency", 128'(n), 128'd11);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("pulse_ignored", 128'(busy), 128'd0);
        repeat (3) @(negedge clk);
        check("pulse_idle", 128'(rk_valid), 128'd0);

        // key changes right after acceptance
        start_exp(1'b0);
        key = {128{1'b1}};
        wait_done();

        // reset at round 5
        start_exp(1'b1);
        n = 0;
        for (int i = 1; i <= 20 && n == 0; i++) begin
            @(negedge clk);
            if (rk_valid && rk_idx == 4'd5) n = i;
        end
        check("reach_idx5", 128'(n), 128'd6);
        rst_n = 1'b0;
        exp_q.delete();
        rd_idx = 4'd3;
        #1;
        check("mid_rst_busy", 128'(busy), 128'd0);
        check("mid_rst_valid", 128'(rk_valid), 128'd0);
        check("mid_rst_done", 128'(done), 128'd0);
        check("mid_rst_ready", 128'(keys_ready), 128'd0);
        check("mid_rst_idx", 128'(rk_idx), 128'd0);
        check("mid_rst_rk", round_key, 128'h0);
        check("mid_rst_slot3", rd_key, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        start_exp(1'b0);
        wait_done();

        // reload zero-key slots with the FIPS key, then overwrite with zero key
        start_exp(1'b1);
        wait_done();
        @(negedge clk);
        key   = ka[0];
        start = 1'b1;
        push_exp(1'b0);
        @(posedge clk);
        #1 start = 1'b0;
        check("ready_dropped", 128'(keys_ready), 128'd0);
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            rd_idx = 4'(k);
            #1 check($sformatf("ovw_new%0d", k), rd_key, ka[k]);
            if (k < 10) begin
                rd_idx = 4'(k + 1);
                #1 check($sformatf("ovw_old%0d", k + 1), rd_key, kb[k + 1]);
            end
            check($sformatf("ovw_ready%0d", k), 128'(keys_ready), 128'd0);
        end
        @(posedge clk);
        #1 check("ovw_ready_end", 128'(keys_ready), 128'd1);
        check("ovw_queue", 128'(exp_q.size()), 128'd0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
